// File: rtl/mem_request_sequencer_pkg.sv
// Shared opcode, access-size and sequencer-state types for the memory request sequencer.
// Opcode values are the MIPS primary opcode field (instruction bits [31:26]).
package mem_request_sequencer_pkg;

  localparam int OPCODE_W = 6;

  typedef enum logic [OPCODE_W-1:0] {
    RTYPE = 6'h00,
    LB    = 6'h20,
    LH    = 6'h21,
    LW    = 6'h23,
    LBU   = 6'h24,
    LHU   = 6'h25,
    SB    = 6'h28,
    SH    = 6'h29,
    SW    = 6'h2B,
    HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  // Counter must hold 0..TIMEOUT; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_request_sequencer_if.sv
// Bundle between the sequencer (master) and the datapath / memory-control side (slave).
interface mem_request_sequencer_if #(
  parameter int WORD_W = 32
);
  localparam int BE_W = WORD_W / 8;

  logic              ihit;
  logic [WORD_W-1:0] ins;
  logic [1:0]        daddr;
  logic              dhit;
  logic              iREN;
  logic              dREN;
  logic              dWEN;
  logic [BE_W-1:0]   dbyte_en;
  logic [WORD_W-1:0] ins_q;
  logic              busy;
  logic              halted;
  logic              misalign_err;
  logic              timeout_err;

  modport master (
    input  ihit, ins, daddr, dhit,
    output iREN, dREN, dWEN, dbyte_en, ins_q, busy, halted, misalign_err, timeout_err
  );

  modport slave (
    output ihit, ins, daddr, dhit,
    input  iREN, dREN, dWEN, dbyte_en, ins_q, busy, halted, misalign_err, timeout_err
  );

endinterface

// File: rtl/mem_request_sequencer_mem_access_decode.sv
// Combinational decode of a primary opcode and low address bits into access kind,
// size, byte-lane enables and a misalignment flag.
module mem_access_decode
  import mem_request_sequencer_pkg::*;
#(
  parameter  int WORD_W = 32,
  localparam int BE_W   = WORD_W / 8
) (
  input  logic [OPCODE_W-1:0] op_i,
  input  logic [1:0]          daddr_i,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                is_halt_o,
  output mem_size_t           size_o,
  output logic [BE_W-1:0]     byte_en_o,
  output logic                misaligned_o
);

  logic is_mem;

  always_comb begin
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    size_o     = WORD;
    case (op_i)
      LW:       is_load_o = 1'b1;
      LH, LHU:  begin is_load_o  = 1'b1; size_o = HALF; end
      LB, LBU:  begin is_load_o  = 1'b1; size_o = BYTE; end
      SW:       is_store_o = 1'b1;
      SH:       begin is_store_o = 1'b1; size_o = HALF; end
      SB:       begin is_store_o = 1'b1; size_o = BYTE; end
      default:  ;
    endcase
  end

  assign is_halt_o = (op_i == HALT);
  assign is_mem    = is_load_o | is_store_o;

  always_comb begin
    misaligned_o = 1'b0;
    if (is_mem) begin
      case (size_o)
        WORD:    misaligned_o = (daddr_i != 2'b00);
        HALF:    misaligned_o = daddr_i[0];
        default: misaligned_o = 1'b0;
      endcase
    end
  end

  // Halfword lanes pair up as {1,0} or {3,2}, selected by daddr[1].
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign byte_en_o[gi] = is_mem &&
                           ((size_o == WORD) ||
                            (size_o == HALF && gi < 4 && (gi / 2) == int'(daddr_i[1])) ||
                            (size_o == BYTE && gi == int'(daddr_i)));
  end

endmodule

// File: rtl/mem_request_sequencer.sv
// Fetch/data request sequencer: stalls fetch during loads/stores, drives byte lanes,
// flags misaligned accesses and data-wait timeouts, and stops permanently on HALT.
module mem_request_sequencer
  import mem_request_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int WORD_W  = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  mem_request_sequencer_if.master bus
);

  localparam int BE_W  = WORD_W / 8;
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

  seq_state_t        state_q;
  logic [WORD_W-1:0] ins_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              misalign_err_q;
  logic              timeout_err_q;

  logic              in_load, in_store, in_halt, in_misaligned;
  mem_size_t         in_size;
  logic [BE_W-1:0]   in_byte_en;
  logic              q_load, q_store, q_halt, q_misaligned;
  mem_size_t         q_size;
  logic [BE_W-1:0]   q_byte_en;
  logic              timeout_hit;
  logic              unused_dec;

  mem_access_decode #(.WORD_W(WORD_W)) u_dec_in (
    .op_i         (bus.ins[WORD_W-1 -: OPCODE_W]),
    .daddr_i      (bus.daddr),
    .is_load_o    (in_load),
    .is_store_o   (in_store),
    .is_halt_o    (in_halt),
    .size_o       (in_size),
    .byte_en_o    (in_byte_en),
    .misaligned_o (in_misaligned)
  );

  mem_access_decode #(.WORD_W(WORD_W)) u_dec_q (
    .op_i         (ins_q[WORD_W-1 -: OPCODE_W]),
    .daddr_i      (bus.daddr),
    .is_load_o    (q_load),
    .is_store_o   (q_store),
    .is_halt_o    (q_halt),
    .size_o       (q_size),
    .byte_en_o    (q_byte_en),
    .misaligned_o (q_misaligned)
  );

  assign unused_dec  = ^{in_size, in_byte_en, q_halt, q_size, q_misaligned};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= FETCH;
      ins_q          <= '0;
      cnt_q          <= '0;
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      case (state_q)
        FETCH: begin
          if (bus.ihit) begin
            ins_q <= bus.ins;
            if (in_halt) begin
              state_q <= HALTED;
            end else if (in_load || in_store) begin
              if (in_misaligned) begin
                misalign_err_q <= 1'b1;
              end else begin
                state_q <= DATA;
                cnt_q   <= '0;
              end
            end
          end
        end
        DATA: begin
          // A completing access in the expiry cycle takes priority over the timeout.
          if (bus.dhit) begin
            state_q <= FETCH;
          end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
            state_q       <= FETCH;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HALTED:  state_q <= HALTED;
        default: state_q <= FETCH;
      endcase
    end
  end

  assign bus.iREN         = (state_q == FETCH);
  assign bus.dREN         = (state_q == DATA) && q_load;
  assign bus.dWEN         = (state_q == DATA) && q_store && !q_load;
  assign bus.dbyte_en     = (state_q == DATA) ? q_byte_en : '0;
  assign bus.ins_q        = ins_q;
  assign bus.busy         = (state_q == DATA);
  assign bus.halted       = (state_q == HALTED);
  assign bus.misalign_err = misalign_err_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule
